car_sprite_render: RTL and testbench

//   Pipelined per-pixel sprite stage for the player car. Takes VGA scan counters and car

---
 rtl/car_sprite_if.sv | 26 ++
 rtl/car_sprite_render.sv | 74 +++++++
 tb/tb_car_sprite_render.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/car_sprite_if.sv
// Scan position, car pose, sprite ROM port and keyed colour output for the car sprite stage.
// The master drives scan/pose/ROM data; the slave (render stage) returns ROM coords and colour.
interface car_sprite_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        video_valid;
    logic [9:0]  car_x;
    logic [9:0]  car_y;
    logic [8:0]  car_deg;
    logic [8:0]  sprite_deg;
    logic [6:0]  sprite_px;
    logic [6:0]  sprite_py;
    logic [11:0] rom_data;
    logic [11:0] car_rgb;
    logic        car_opaque;

    modport master (
        output h_cnt, v_cnt, video_valid, car_x, car_y, car_deg, rom_data,
        input  sprite_deg, sprite_px, sprite_py, car_rgb, car_opaque
    );

    modport slave (
        input  h_cnt, v_cnt, video_valid, car_x, car_y, car_deg, rom_data,
        output sprite_deg, sprite_px, sprite_py, car_rgb, car_opaque
    );
endinterface

// File: rtl/car_sprite_render.sv
// Pipelined per-pixel player-car sprite stage: scan position -> sprite ROM coords -> keyed RGB.
// Pose is shadowed once per frame on the first blanking line so the car never tears mid-frame.
module car_sprite_render #(
    parameter int          SPRITE_W  = 75,
    parameter int          SPRITE_H  = 75,
    parameter int          ROM_LAT   = 1,
    parameter logic [11:0] KEY_COLOR = 12'h000,
    parameter int          LATCH_V   = 480
) (
    input  logic         clk,
    input  logic         rst,
    car_sprite_if.slave  bus
);
    logic [9:0]         sh_x;
    logic [9:0]         sh_y;
    logic [8:0]         sh_deg;
    logic               in_box_s1;
    logic [ROM_LAT-1:0] in_box_sr;

    logic [10:0] h_ext, v_ext, sx_ext, sy_ext, dx, dy;
    logic        in_box;

    // 11-bit compares so sx+SPRITE_W near the right edge cannot wrap
    always_comb begin
        h_ext  = {1'b0, bus.h_cnt};
        v_ext  = {1'b0, bus.v_cnt};
        sx_ext = {1'b0, sh_x};
        sy_ext = {1'b0, sh_y};
        dx     = h_ext - sx_ext;
        dy     = v_ext - sy_ext;
        in_box = bus.video_valid
                 && (h_ext >= sx_ext) && (h_ext < sx_ext + 11'(SPRITE_W))
                 && (v_ext >= sy_ext) && (v_ext < sy_ext + 11'(SPRITE_H));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x           <= '0;
            sh_y           <= '0;
            sh_deg         <= '0;
            in_box_s1      <= 1'b0;
            in_box_sr      <= '0;
            bus.sprite_deg <= '0;
            bus.sprite_px  <= '0;
            bus.sprite_py  <= '0;
            bus.car_rgb    <= '0;
            bus.car_opaque <= 1'b0;
        end else begin
            if (bus.v_cnt == 10'(LATCH_V) && bus.h_cnt == 10'd0) begin
                sh_x   <= bus.car_x;
                sh_y   <= bus.car_y;
                sh_deg <= (bus.car_deg >= 9'd360) ? 9'd0 : bus.car_deg;
            end

            // Out-of-box coords forced to 0 so the ROM address stays in range
            in_box_s1      <= in_box;
            bus.sprite_deg <= sh_deg;
            bus.sprite_px  <= in_box ? dx[6:0] : 7'd0;
            bus.sprite_py  <= in_box ? dy[6:0] : 7'd0;

            in_box_sr[0] <= in_box_s1;
            for (int i = 1; i < ROM_LAT; i++)
                in_box_sr[i] <= in_box_sr[i-1];

            if (in_box_sr[ROM_LAT-1] && bus.rom_data != KEY_COLOR) begin
                bus.car_opaque <= 1'b1;
                bus.car_rgb    <= bus.rom_data;
            end else begin
                bus.car_opaque <= 1'b0;
                bus.car_rgb    <= 12'h000;
            end
        end
    end
endmodule

// File: tb/tb_car_sprite_render.sv
// Directed bench for car_sprite_render: reset, box edges, colour keying, frame-latched pose.
module tb_car_sprite_render;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    car_sprite_if bus ();

    car_sprite_render dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic park();
        bus.h_cnt       = 10'd700;
        bus.v_cnt       = 10'd500;
        bus.video_valid = 1'b0;
    endtask

    // Pose captured on the latch line; sprite_deg reflects it one cycle later
    task automatic latch_pose(input logic [9:0] x, input logic [9:0] y, input logic [8:0] d);
        bus.car_x   = x;
        bus.car_y   = y;
        bus.car_deg = d;
        bus.h_cnt   = 10'd0;
        bus.v_cnt   = 10'd480;
        bus.video_valid = 1'b0;
        step();
        park();
        step();
    endtask

    // One pixel through the pipe: coords after 1 edge, ROM word before edge 3, colour after edge 3
    task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v, input logic vv,
                       input logic [11:0] rom, input logic [6:0] epx, input logic [6:0] epy,
                       input logic eop, input logic [11:0] ergb);
        bus.h_cnt       = h;
        bus.v_cnt       = v;
        bus.video_valid = vv;
        step();
        chk({tag, "_px"}, 32'(bus.sprite_px), 32'(epx));
        chk({tag, "_py"}, 32'(bus.sprite_py), 32'(epy));
        park();
        step();
        bus.rom_data = rom;
        step();
        chk({tag, "_opaque"}, 32'(bus.car_opaque), 32'(eop));
        chk({tag, "_rgb"}, 32'(bus.car_rgb), 32'(ergb));
        bus.rom_data = 12'h000;
    endtask

    initial begin
        park();
        bus.car_x    = 10'd0;
        bus.car_y    = 10'd0;
        bus.car_deg  = 9'd77;
        bus.rom_data = 12'hABC;

        // T1: reset, with the latch line asserted during reset (reset must win)
        rst = 1'b1;
        bus.h_cnt = 10'd0;
        bus.v_cnt = 10'd480;
        repeat (5) step();
        chk("rst_opaque", 32'(bus.car_opaque), 32'd0);
        chk("rst_rgb", 32'(bus.car_rgb), 32'd0);
        chk("rst_px", 32'(bus.sprite_px), 32'd0);
        chk("rst_py", 32'(bus.sprite_py), 32'd0);
        chk("rst_deg", 32'(bus.sprite_deg), 32'd0);
        rst = 1'b0;
        park();
        repeat (3) step();
        chk("post_rst_opaque", 32'(bus.car_opaque), 32'd0);
        chk("post_rst_rgb", 32'(bus.car_rgb), 32'd0);
        chk("post_rst_deg", 32'(bus.sprite_deg), 32'd0);

        // T2: basic hit at top-left corner of the sprite
        latch_pose(10'd100, 10'd50, 9'd0);
        chk("t2_deg", 32'(bus.sprite_deg), 32'd0);
        pix("t2", 10'd100, 10'd50, 1'b1, 12'hF00, 7'd0, 7'd0, 1'b1, 12'hF00);

        // T3: right/bottom box edges
        pix("t3_right", 10'd174, 10'd60, 1'b1, 12'h0F0, 7'd74, 7'd10, 1'b1, 12'h0F0);
        pix("t3_out", 10'd175, 10'd60, 1'b1, 12'h0F0, 7'd0, 7'd0, 1'b0, 12'h000);
        pix("t3_bot", 10'd130, 10'd124, 1'b1, 12'h00F, 7'd30, 7'd74, 1'b1, 12'h00F);
        pix("t3_below", 10'd130, 10'd125, 1'b1, 12'h00F, 7'd0, 7'd0, 1'b0, 12'h000);
        pix("t3_left", 10'd99, 10'd60, 1'b1, 12'h00F, 7'd0, 7'd0, 1'b0, 12'h000);

        // T4: key colour is transparent; blanking suppresses the box
        pix("t4_key", 10'd120, 10'd60, 1'b1, 12'h000, 7'd20, 7'd10, 1'b0, 12'h000);
        pix("t4_blank", 10'd120, 10'd60, 1'b0, 12'h123, 7'd0, 7'd0, 1'b0, 12'h000);

        // T5: pose change mid-frame is ignored until the latch line
        latch_pose(10'd100, 10'd50, 9'd30);
        chk("t5_deg30", 32'(bus.sprite_deg), 32'd30);
        bus.car_deg = 9'd200;
        bus.car_x   = 10'd300;
        pix("t5_hold", 10'd100, 10'd200, 1'b1, 12'h111, 7'd0, 7'd0, 1'b0, 12'h000);
        chk("t5_deg_hold", 32'(bus.sprite_deg), 32'd30);
        pix("t5_oldpos", 10'd101, 10'd51, 1'b1, 12'h222, 7'd1, 7'd1, 1'b1, 12'h222);
        latch_pose(10'd100, 10'd50, 9'd200);
        chk("t5_deg200", 32'(bus.sprite_deg), 32'd200);

        // T6: out-of-range heading and car hanging off the right edge
        latch_pose(10'd600, 10'd0, 9'd400);
        chk("t6_deg", 32'(bus.sprite_deg), 32'd0);
        pix("t6_first", 10'd600, 10'd10, 1'b1, 12'h456, 7'd0, 7'd10, 1'b1, 12'h456);
        pix("t6_last", 10'd639, 10'd10, 1'b1, 12'h789, 7'd39, 7'd10, 1'b1, 12'h789);
        pix("t6_before", 10'd599, 10'd10, 1'b1, 12'h789, 7'd0, 7'd0, 1'b0, 12'h000);

        // Reset mid-frame: pipe flushed, pose back to (0,0) deg 0
        bus.h_cnt = 10'd610;
        bus.v_cnt = 10'd20;
        bus.video_valid = 1'b1;
        bus.rom_data = 12'hFFF;
        step();
        step();
        step();
        chk("mid_pre_opaque", 32'(bus.car_opaque), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_opaque", 32'(bus.car_opaque), 32'd0);
        chk("mid_rst_rgb", 32'(bus.car_rgb), 32'd0);
        rst = 1'b0;
        park();
        bus.rom_data = 12'h000;
        pix("mid_origin", 10'd5, 10'd6, 1'b1, 12'hEEE, 7'd5, 7'd6, 1'b1, 12'hEEE);
        chk("mid_deg", 32'(bus.sprite_deg), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
